// File: rtl/uart_flow_ctrl_if.sv
// TX handshake between the flow-control sequencer and the TX FIFO / transmitter.
//   tx_valid : TX FIFO holds at least one character
//   tx_start : one-cycle pulse, transmitter pops and sends one character
//   tx_busy  : transmitter is shifting a character
// master: sequencer side (drives tx_start); slave: FIFO/transmitter side.
interface uart_flow_ctrl_if;
    logic tx_valid;
    logic tx_start;
    logic tx_busy;

    modport master (
        input  tx_valid,
        input  tx_busy,
        output tx_start
    );

    modport slave (
        output tx_valid,
        output tx_busy,
        input  tx_start
    );
endinterface

// File: rtl/uart_flow_ctrl.sv
// UART auto flow control sequencer.
// Drives RTS from RX FIFO fill level with hysteresis, gates each transmitted
// character on a glitch-filtered CTS and flags a transmitter stalled on CTS.
// With auto flow disabled, software RTS passes through and characters launch
// unconditionally.
// Ports:
//   clk_i, rst_ni       : clock, asynchronous active-low reset
//   afe_en_i            : auto flow enable
//   mcr_rts_i           : software RTS (active-high)
//   cts_i               : synchronized CTS (active-high)
//   rx_level_i          : RX FIFO occupancy
//   rx_hi_thresh_i      : level at which RTS drops
//   rx_lo_thresh_i      : level at which RTS is restored
//   rx_start_i          : receiver saw a start bit (one-cycle pulse)
//   tx_if               : TX handshake (tx_valid/tx_busy in, tx_start out)
//   stall_timeout_i     : stall limit in cycles, 0 disables
//   rts_o, cts_filt_o   : registered RTS request and filtered CTS
//   stall_o             : one-cycle stall pulse
module uart_flow_ctrl #(
    parameter int unsigned FifoDepth = 16,
    parameter int unsigned LevelW    = $clog2(FifoDepth + 1),
    parameter int unsigned CtsFilter = 4,
    parameter int unsigned TimeoutW  = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                afe_en_i,
    input  logic                mcr_rts_i,
    input  logic                cts_i,
    input  logic [LevelW-1:0]   rx_level_i,
    input  logic [LevelW-1:0]   rx_hi_thresh_i,
    input  logic [LevelW-1:0]   rx_lo_thresh_i,
    input  logic                rx_start_i,
    uart_flow_ctrl_if.master    tx_if,
    input  logic [TimeoutW-1:0] stall_timeout_i,
    output logic                rts_o,
    output logic                cts_filt_o,
    output logic                stall_o
);

    localparam int unsigned CntW = $clog2(CtsFilter + 1);
    localparam logic [CntW-1:0] CtsLimit = CntW'(CtsFilter);

    typedef enum logic [2:0] {
        StIdle,
        StLaunch,
        StWaitBusy,
        StBusy,
        StStall
    } tx_state_e;

    // ---------------------------------------------------------------- CTS filter
    logic [CntW-1:0] cts_cnt_q, cts_cnt_d, cts_cnt_inc;
    logic            cts_filt_q, cts_filt_d;

    assign cts_cnt_inc = cts_cnt_q + CntW'(1);

    always_comb begin
        cts_cnt_d  = '0;
        cts_filt_d = cts_filt_q;
        if (cts_i != cts_filt_q) begin
            // The sample that completes the run flips the output directly, so a
            // change stable from cycle n is visible at n+CtsFilter.
            if (cts_cnt_inc == CtsLimit) begin
                cts_filt_d = ~cts_filt_q;
            end else begin
                cts_cnt_d = cts_cnt_inc;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cts_cnt_q  <= '0;
            cts_filt_q <= 1'b0;
        end else begin
            cts_cnt_q  <= cts_cnt_d;
            cts_filt_q <= cts_filt_d;
        end
    end

    assign cts_filt_o = cts_filt_q;

    // ------------------------------------------------------- RX gate and RTS
    logic              rx_ok_q, rx_ok_d;
    logic              rx_clr, rx_set;
    logic              rts_q, rts_d;
    logic [LevelW-1:0] hi_m1;

    assign hi_m1 = rx_hi_thresh_i - LevelW'(1);

    // A start bit at hi-1 means the FIFO reaches hi before RTS could act, so drop
    // early. The hi-1 term is meaningless (would wrap) when hi is zero.
    assign rx_clr = (rx_level_i >= rx_hi_thresh_i) ||
                    ((rx_hi_thresh_i != '0) && rx_start_i && (rx_level_i == hi_m1));
    assign rx_set = (rx_level_i <= rx_lo_thresh_i);

    always_comb begin
        rx_ok_d = rx_ok_q;
        if (rx_clr) begin
            rx_ok_d = 1'b0;
        end else if (rx_set) begin
            rx_ok_d = 1'b1;
        end
    end

    assign rts_d = mcr_rts_i & (rx_ok_d | ~afe_en_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_ok_q <= 1'b1;
            rts_q   <= 1'b0;
        end else begin
            rx_ok_q <= rx_ok_d;
            rts_q   <= rts_d;
        end
    end

    assign rts_o = rts_q;

    // ----------------------------------------------- TX FSM and stall counter
    tx_state_e         state_q;
    logic              tx_start_q;
    logic              stall_q;
    logic              stall_fired_q;
    logic [TimeoutW-1:0] stall_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            tx_start_q    <= 1'b0;
            stall_q       <= 1'b0;
            stall_fired_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            tx_start_q <= 1'b0;
            stall_q    <= 1'b0;

            case (state_q)
                StIdle: begin
                    if (tx_if.tx_valid) begin
                        if (!afe_en_i || cts_filt_q) begin
                            state_q    <= StLaunch;
                            tx_start_q <= 1'b1;
                        end else begin
                            state_q <= StStall;
                        end
                    end
                end
                StLaunch: begin
                    state_q <= StWaitBusy;
                end
                // No timeout here: the transmitter is required to respond.
                StWaitBusy: begin
                    if (tx_if.tx_busy) begin
                        state_q <= StBusy;
                    end
                end
                // CTS is deliberately ignored mid-character.
                StBusy: begin
                    if (!tx_if.tx_busy) begin
                        state_q <= StIdle;
                    end
                end
                // Exit via IDLE so launch is decided in one place.
                StStall: begin
                    if (!tx_if.tx_valid || !afe_en_i || cts_filt_q) begin
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase

            if (state_q == StStall) begin
                if (stall_cnt_q != '1) begin
                    stall_cnt_q <= stall_cnt_q + TimeoutW'(1);
                end
                // The fired flag covers a timeout of all-ones, where the
                // saturated count would otherwise match every cycle.
                if ((stall_timeout_i != '0) && (stall_cnt_q == stall_timeout_i) &&
                    !stall_fired_q) begin
                    stall_q       <= 1'b1;
                    stall_fired_q <= 1'b1;
                end
            end else begin
                stall_cnt_q   <= '0;
                stall_fired_q <= 1'b0;
            end
        end
    end

    assign tx_if.tx_start = tx_start_q;
    assign stall_o        = stall_q;

endmodule

// File: tb/tb_uart_flow_ctrl.sv
// Self-checking bench for uart_flow_ctrl: directed scenarios plus a randomized
// run of the RTS hysteresis and CTS filter against a behavioural model.
module tb_uart_flow_ctrl;

    localparam int unsigned FifoDepth = 16;
    localparam int unsigned LevelW    = 5;
    localparam int unsigned CtsFilter = 4;
    localparam int unsigned TimeoutW  = 16;
    localparam int          BusyLen   = 10;

    logic                clk = 1'b0;
    logic                rst_ni;
    logic                afe_en;
    logic                mcr_rts;
    logic                cts;
    logic [LevelW-1:0]   rx_level;
    logic [LevelW-1:0]   rx_hi;
    logic [LevelW-1:0]   rx_lo;
    logic                rx_start;
    logic [TimeoutW-1:0] stall_timeout;
    logic                rts;
    logic                cts_filt;
    logic                stall;

    uart_flow_ctrl_if tx_if ();

    uart_flow_ctrl #(
        .FifoDepth (FifoDepth),
        .LevelW    (LevelW),
        .CtsFilter (CtsFilter),
        .TimeoutW  (TimeoutW)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .afe_en_i        (afe_en),
        .mcr_rts_i       (mcr_rts),
        .cts_i           (cts),
        .rx_level_i      (rx_level),
        .rx_hi_thresh_i  (rx_hi),
        .rx_lo_thresh_i  (rx_lo),
        .rx_start_i      (rx_start),
        .tx_if           (tx_if),
        .stall_timeout_i (stall_timeout),
        .rts_o           (rts),
        .cts_filt_o      (cts_filt),
        .stall_o         (stall)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Transmitter model: raises busy the cycle after tx_start, holds BusyLen
    // cycles. When disabled it drives xm_hold instead.
    bit   xm_en   = 1'b0;
    bit   xm_hold = 1'b0;
    int   xm_rem  = 0;
    logic xm_st;

    always @(posedge clk) begin
        xm_st = tx_if.tx_start;
        #1;
        if (!xm_en) begin
            xm_rem = 0;
            tx_if.tx_busy = xm_hold;
        end else begin
            if (xm_st) xm_rem = BusyLen;
            else if (xm_rem > 0) xm_rem--;
            tx_if.tx_busy = (xm_rem > 0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
        cyc++;
    endtask

    task automatic defaults();
        afe_en         = 1'b0;
        mcr_rts        = 1'b0;
        cts            = 1'b0;
        rx_level       = '0;
        rx_hi          = 5'd12;
        rx_lo          = 5'd4;
        rx_start       = 1'b0;
        tx_if.tx_valid = 1'b0;
        stall_timeout  = '0;
        xm_en          = 1'b0;
        xm_hold        = 1'b0;
        step();
    endtask

    // Release lands mid-cycle; cyc counts rising edges after release.
    task automatic do_reset();
        rst_ni = 1'b0;
        repeat (2) step();
        rst_ni = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        defaults();
        afe_en   = 1'b1;
        mcr_rts  = 1'b1;
        rx_level = 5'd8;  // between lo and hi: rx_ok keeps its reset value
        rst_ni   = 1'b0;
        step();
        checks++; if (rts !== 1'b0) begin errors++; $display("FAIL reset_rts got %b exp 0", rts); end
        checks++; if (tx_if.tx_start !== 1'b0) begin errors++; $display("FAIL reset_tx_start got %b exp 0", tx_if.tx_start); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
        checks++; if (cts_filt !== 1'b0) begin errors++; $display("FAIL reset_cts_filt got %b exp 0", cts_filt); end
        rst_ni = 1'b1;
        cyc = 0;
        step();
        checks++; if (rts !== 1'b1) begin errors++; $display("FAIL reset_rx_ok_one got rts=%b exp 1", rts); end
    endtask

    task automatic test_afe_off_launch();
        int first = -1;
        int last  = -1;
        int n     = 0;
        defaults();
        mcr_rts = 1'b1;
        tx_if.tx_valid = 1'b1;
        xm_en = 1'b1;
        do_reset();
        // LAUNCH + WAIT_BUSY + 10 busy + IDLE = 13 cycles per character.
        for (int i = 0; i < 60; i++) begin
            step();
            checks++; if (rts !== 1'b1) begin errors++; $display("FAIL afe_off_rts cyc %0d got %b exp 1", cyc, rts); end
            if (tx_if.tx_start === 1'b1) begin
                if (first < 0) first = cyc;
                else begin
                    checks++;
                    if (cyc - last !== 13) begin
                        errors++; $display("FAIL afe_off_spacing got %0d exp 13", cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
        end
        checks++; if (first !== 1) begin errors++; $display("FAIL afe_off_first got %0d exp 1", first); end
        checks++; if (n !== 5) begin errors++; $display("FAIL afe_off_count got %0d exp 5", n); end
    endtask

    task automatic test_stall();
        int n_stall = 0;
        int at      = -1;
        int starts  = 0;
        int c0;
        int filt_at  = -1;
        int start_at = -1;
        defaults();
        afe_en = 1'b1;
        mcr_rts = 1'b1;
        tx_if.tx_valid = 1'b1;
        stall_timeout = 16'd20;
        xm_en = 1'b1;
        do_reset();
        // STALL entered at cycle 1, so the pulse lands at 1+20+1.
        for (int i = 0; i < 40; i++) begin
            step();
            if (stall === 1'b1) begin n_stall++; at = cyc; end
            if (tx_if.tx_start === 1'b1) starts++;
        end
        checks++; if (n_stall !== 1) begin errors++; $display("FAIL stall_count got %0d exp 1", n_stall); end
        checks++; if (at !== 22) begin errors++; $display("FAIL stall_cycle got %0d exp 22", at); end
        checks++; if (starts !== 0) begin errors++; $display("FAIL stall_no_launch got %0d exp 0", starts); end
        c0 = cyc;
        cts = 1'b1;
        // Filter output at c0+4, STALL->IDLE at c0+5, LAUNCH at c0+6.
        for (int i = 0; i < 12; i++) begin
            step();
            if (cts_filt === 1'b1 && filt_at < 0) filt_at = cyc;
            if (tx_if.tx_start === 1'b1 && start_at < 0) start_at = cyc;
        end
        checks++; if (filt_at !== c0 + 4) begin errors++; $display("FAIL stall_cts_filt got %0d exp %0d", filt_at, c0 + 4); end
        checks++; if (start_at !== c0 + 6) begin errors++; $display("FAIL stall_release_launch got %0d exp %0d", start_at, c0 + 6); end
    endtask

    task automatic test_cts_glitch();
        int c0;
        int rise = -1;
        int high = 0;
        bit saw;
        defaults();
        afe_en = 1'b1;
        tx_if.tx_valid = 1'b1;
        xm_en = 1'b1;
        do_reset();
        repeat (2) step();
        for (int len = 1; len < int'(CtsFilter); len++) begin
            saw = 1'b0;
            cts = 1'b1;
            repeat (len) begin
                step();
                if (cts_filt !== 1'b0 || tx_if.tx_start !== 1'b0) saw = 1'b1;
            end
            cts = 1'b0;
            repeat (6) begin
                step();
                if (cts_filt !== 1'b0 || tx_if.tx_start !== 1'b0) saw = 1'b1;
            end
            checks++; if (saw !== 1'b0) begin errors++; $display("FAIL glitch_len%0d got change=1 exp 0", len); end
        end
        tx_if.tx_valid = 1'b0;
        repeat (2) step();
        c0 = cyc;
        cts = 1'b1;
        // 4-cycle pulse: filt rises at c0+4, then the low input pulls it back
        // after another 4 cycles.
        for (int k = 1; k <= 14; k++) begin
            step();
            if (cts_filt === 1'b1) begin
                if (rise < 0) rise = cyc;
                high++;
            end
            cts = (k < 4);
        end
        checks++; if (rise !== c0 + 4) begin errors++; $display("FAIL pulse4_rise got %0d exp %0d", rise, c0 + 4); end
        checks++; if (high !== 4) begin errors++; $display("FAIL pulse4_width got %0d exp 4", high); end
    endtask

    task automatic test_rts_hysteresis();
        defaults();
        afe_en = 1'b1;
        mcr_rts = 1'b1;
        do_reset();
        step();
        checks++; if (rts !== 1'b1) begin errors++; $display("FAIL rts_initial got %b exp 1", rts); end
        rx_level = 5'd10; rx_start = 1'b1;
        step();
        checks++; if (rts !== 1'b1) begin errors++; $display("FAIL rts_hi_minus2_start got %b exp 1", rts); end
        rx_level = 5'd11;
        step();
        checks++; if (rts !== 1'b0) begin errors++; $display("FAIL rts_hi_minus1_start got %b exp 0", rts); end
        rx_start = 1'b0;
        for (int l = 5; l <= 11; l++) begin
            rx_level = 5'(l);
            step();
            checks++; if (rts !== 1'b0) begin errors++; $display("FAIL rts_hold_lvl%0d got %b exp 0", l, rts); end
        end
        rx_level = 5'd4;
        step();
        checks++; if (rts !== 1'b1) begin errors++; $display("FAIL rts_restore got %b exp 1", rts); end
        rx_level = 5'd11;
        step();
        checks++; if (rts !== 1'b1) begin errors++; $display("FAIL rts_hi_minus1_nostart got %b exp 1", rts); end
        rx_level = 5'd12;
        step();
        checks++; if (rts !== 1'b0) begin errors++; $display("FAIL rts_at_hi got %b exp 0", rts); end
        afe_en = 1'b0;
        step();
        checks++; if (rts !== 1'b1) begin errors++; $display("FAIL rts_afe_off got %b exp 1", rts); end
        afe_en = 1'b1;
        rx_level = 5'd2;
        step();
        checks++; if (rts !== 1'b1) begin errors++; $display("FAIL rts_low_level got %b exp 1", rts); end
        rx_hi = 5'd4; rx_lo = 5'd8; rx_level = 5'd6;
        step();
        checks++; if (rts !== 1'b0) begin errors++; $display("FAIL rts_misconfig got %b exp 0", rts); end
        rx_hi = 5'd12; rx_lo = 5'd4; rx_level = 5'd0; mcr_rts = 1'b0;
        step();
        checks++; if (rts !== 1'b0) begin errors++; $display("FAIL rts_sw_off got %b exp 0", rts); end
    endtask

    task automatic test_cts_drop_busy();
        int l_at   = -1;
        int fall   = -1;
        int st_at  = -1;
        int starts = 0;
        defaults();
        afe_en = 1'b1;
        cts = 1'b1;
        stall_timeout = 16'd5;
        xm_en = 1'b1;
        do_reset();
        repeat (6) step();
        tx_if.tx_valid = 1'b1;
        for (int i = 0; i < 5 && l_at < 0; i++) begin
            step();
            if (tx_if.tx_start === 1'b1) l_at = cyc;
        end
        checks++; if (l_at !== 7) begin errors++; $display("FAIL drop_first_launch got %0d exp 7", l_at); end
        if (l_at < 0) l_at = cyc;
        repeat (3) step();
        cts = 1'b0;
        // Busy L+1..L+10, IDLE at L+12, STALL at L+13, pulse at L+13+5+1.
        for (int i = 0; i < 27; i++) begin
            step();
            if (tx_if.tx_busy === 1'b0 && fall < 0) fall = cyc;
            if (stall === 1'b1 && st_at < 0) st_at = cyc;
            if (tx_if.tx_start === 1'b1) starts++;
        end
        checks++; if (fall !== l_at + 11) begin errors++; $display("FAIL drop_char_done got %0d exp %0d", fall, l_at + 11); end
        checks++; if (st_at !== l_at + 19) begin errors++; $display("FAIL drop_stall got %0d exp %0d", st_at, l_at + 19); end
        checks++; if (starts !== 0) begin errors++; $display("FAIL drop_no_launch got %0d exp 0", starts); end
    endtask

    task automatic test_reset_mid_char();
        defaults();
        mcr_rts = 1'b1;
        cts = 1'b1;
        tx_if.tx_valid = 1'b1;
        xm_en = 1'b1;
        do_reset();
        repeat (6) step();  // launch at 1, BUSY from 3; filtered CTS high from 4
        xm_en = 1'b0;
        xm_hold = 1'b1;
        step();
        cts = 1'b0;
        rst_ni = 1'b0;
        #1;
        checks++; if (rts !== 1'b0) begin errors++; $display("FAIL midrst_rts got %b exp 0", rts); end
        checks++; if (cts_filt !== 1'b0) begin errors++; $display("FAIL midrst_cts_filt got %b exp 0", cts_filt); end
        checks++; if (tx_if.tx_start !== 1'b0) begin errors++; $display("FAIL midrst_tx_start got %b exp 0", tx_if.tx_start); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL midrst_stall got %b exp 0", stall); end
        repeat (2) step();
        rst_ni = 1'b1;
        cyc = 0;
        step();
        checks++; if (tx_if.tx_start !== 1'b1) begin errors++; $display("FAIL midrst_launch got %b exp 1", tx_if.tx_start); end
        step();
        checks++; if (tx_if.tx_start !== 1'b0) begin errors++; $display("FAIL midrst_single_pulse got %b exp 0", tx_if.tx_start); end
    endtask

    // Model: filtered CTS flips once the last CtsFilter samples all differ from
    // it; RTS follows the hysteresis rule on occupancy.
    task automatic test_random();
        bit m_filt  = 1'b0;
        bit m_rx_ok = 1'b1;
        bit m_rts;
        bit hist[$];
        bit all_diff;
        bit clr;
        bit set;
        int lvl = 0;
        defaults();
        do_reset();
        for (int i = 0; i < 600; i++) begin
            afe_en  = ($urandom_range(0, 7) != 0);
            mcr_rts = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) cts = ~cts;
            if ($urandom_range(0, 31) == 0) begin
                rx_hi = 5'($urandom_range(0, 16));
                rx_lo = 5'($urandom_range(0, 16));
            end
            lvl = lvl + int'($urandom_range(0, 4)) - 2;
            if (lvl < 0) lvl = 0;
            if (lvl > 16) lvl = 16;
            rx_level = 5'(lvl);
            rx_start = ($urandom_range(0, 3) == 0);

            hist.push_back(cts);
            if (hist.size() > CtsFilter) void'(hist.pop_front());
            if (hist.size() == CtsFilter) begin
                all_diff = 1'b1;
                foreach (hist[j]) if (hist[j] == m_filt) all_diff = 1'b0;
                if (all_diff) m_filt = ~m_filt;
            end
            clr = (lvl >= int'(rx_hi)) || (rx_hi != 0 && rx_start && lvl == int'(rx_hi) - 1);
            set = (lvl <= int'(rx_lo));
            if (clr) m_rx_ok = 1'b0;
            else if (set) m_rx_ok = 1'b1;
            m_rts = mcr_rts && (m_rx_ok || !afe_en);

            step();
            checks++; if (rts !== m_rts) begin errors++; $display("FAIL rand_rts iter %0d got %b exp %b", i, rts, m_rts); end
            checks++; if (cts_filt !== m_filt) begin errors++; $display("FAIL rand_cts_filt iter %0d got %b exp %b", i, cts_filt, m_filt); end
            checks++; if (tx_if.tx_start !== 1'b0) begin errors++; $display("FAIL rand_tx_start iter %0d got %b exp 0", i, tx_if.tx_start); end
        end
    endtask

    initial begin
        rst_ni         = 1'b0;
        tx_if.tx_valid = 1'b0;
        test_reset();
        test_afe_off_launch();
        test_stall();
        test_cts_glitch();
        test_rts_hysteresis();
        test_cts_drop_busy();
        test_reset_mid_char();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
